// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter in front of the UART transmitter byte stream.
// Defining UART_TX_ARB_HEADER_EN adds a {4'hA, owner} header byte ahead of every granted frame.
module uart_tx_arbiter #(
  parameter int unsigned REQ_COUNT     = 4,
  parameter int unsigned MAX_FRAME_LEN = 64,
  parameter int unsigned IDX_WIDTH     = $clog2(REQ_COUNT)
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [REQ_COUNT-1:0][7:0] req_data_i,
  input  logic [REQ_COUNT-1:0]      req_valid_i,
  input  logic [REQ_COUNT-1:0]      req_last_i,
  output logic [REQ_COUNT-1:0]      req_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [REQ_COUNT-1:0]      grant_o,
  output logic                      busy_o,
  output logic                      frame_abort_o,
  output logic [7:0]                abort_count_o
);

  localparam int unsigned CNT_W = 8;

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, HDR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1} state_t;
`endif

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] gidx, gidx_n;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_n, rr_next;
  logic [IDX_WIDTH-1:0] pick;
  logic                 pick_ok;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [7:0]           abort_cnt_n;
  logic                 abort_n;
  logic [REQ_COUNT-1:0] grant_n;

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    int unsigned k;
    pick    = '0;
    pick_ok = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      k = (32'(rr_ptr) + i) % REQ_COUNT;
      if (!pick_ok && req_valid_i[IDX_WIDTH'(k)]) begin
        pick    = IDX_WIDTH'(k);
        pick_ok = 1'b1;
      end
    end
  end

  assign rr_next = (32'(gidx) == REQ_COUNT - 1) ? '0 : IDX_WIDTH'(32'(gidx) + 1);

  always_comb begin
    state_n     = state;
    gidx_n      = gidx;
    rr_ptr_n    = rr_ptr;
    cnt_n       = cnt;
    abort_n     = 1'b0;
    abort_cnt_n = abort_count_o;
    tx_data_o   = '0;
    tx_valid_o  = 1'b0;
    req_ready_o = '0;
    grant_n     = '0;

    case (state)
      IDLE: begin
        if (pick_ok) begin
          gidx_n = pick;
          cnt_n  = '0;
`ifdef UART_TX_ARB_HEADER_EN
          state_n = HDR;
`else
          state_n = PASS;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      HDR: begin
        tx_data_o  = {4'hA, 4'(gidx)};
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_n = PASS;
      end
`endif
      PASS: begin
        tx_data_o         = req_data_i[gidx];
        tx_valid_o        = req_valid_i[gidx];
        req_ready_o[gidx] = tx_ready_i;
        if (req_valid_i[gidx] && tx_ready_i) begin
          if (req_last_i[gidx]) begin
            state_n  = IDLE;
            rr_ptr_n = rr_next;
            cnt_n    = '0;
          end else if (cnt == CNT_W'(MAX_FRAME_LEN - 1)) begin
            // Frame overran its budget: release so others get the line.
            state_n     = IDLE;
            rr_ptr_n    = rr_next;
            cnt_n       = '0;
            abort_n     = 1'b1;
            abort_cnt_n = (abort_count_o == 8'hFF) ? 8'hFF : abort_count_o + 8'd1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != IDLE) grant_n[gidx_n] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= IDLE;
      gidx          <= '0;
      rr_ptr        <= '0;
      cnt           <= '0;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      frame_abort_o <= 1'b0;
      abort_count_o <= '0;
    end else begin
      state         <= state_n;
      gidx          <= gidx_n;
      rr_ptr        <= rr_ptr_n;
      cnt           <= cnt_n;
      grant_o       <= grant_n;
      busy_o        <= (state_n != IDLE);
      frame_abort_o <= abort_n;
      abort_count_o <= abort_cnt_n;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter byte stream between REQ_COUNT byte-stream requesters, e.g. command responder, PMU streamer and idle-status reporter.
- Grants whole frames, delimited by a last flag, in round-robin order, so bytes from different requesters never interleave on tx.
- Sits between the requesters and the transmitter's data/valid/ready input inside the UART control subsystem.

Parameters:
- REQ_COUNT, 4, number of requesters (2..16).
- MAX_FRAME_LEN, 64, maximum bytes accepted per grant before forced release (1..255).
- IDX_WIDTH, $clog2(REQ_COUNT), derived; width of the requester index.

Ports:
- clk_i  input  1  clock.
- arst_i  input  1  reset. One clock; reset is asynchronous and active-high.
- req_data_i  input  8 x [REQ_COUNT]  per-requester byte.
- req_valid_i  input  1 x [REQ_COUNT]  per-requester byte valid.
- req_last_i  input  1 x [REQ_COUNT]  marks the final byte of the frame; qualified by valid.
- req_ready_o  output  1 x [REQ_COUNT]  per-requester byte accepted.
- tx_data_o  output  8  byte to transmitter.
- tx_valid_o  output  1  byte valid to transmitter.
- tx_ready_i  input  1  transmitter ready.
- grant_o  output  REQ_COUNT  one-hot current owner; zero when idle.
- busy_o  output  1  a frame is in progress.
- frame_abort_o  output  1  one-cycle pulse on forced release.
- abort_count_o  output  8  saturating count of forced releases.

Behaviour:
- Reset (async, arst_i=1): state=IDLE, grant_o=0, busy_o=0, frame_abort_o=0, abort_count_o=0, rr_ptr=0, byte counter=0. Combinational outputs tx_valid_o, tx_data_o and req_ready_o are 0 while idle.
- Handshake: a byte transfers when tx_valid_o && tx_ready_i in the same cycle. req_ready_o[g] = tx_ready_i only for the granted g; all other ready bits are 0. tx_data_o/tx_valid_o are combinational mux of granted requester.
- State IDLE:
  - If any req_valid_i is high, select the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo REQ_COUNT.
  - Register the grant and go to PASS (HDR if feature enabled).
  - Arbitration bubble is 1 cycle: no byte is transferred in the IDLE cycle.
- State PASS:
  - Grant is held regardless of req_valid_i gaps; a requester dropping valid mid-frame stalls tx and does not lose the grant.
  - Each transfer increments the byte counter (8-bit).
  - Transfer with req_last_i=1: return to IDLE next cycle, set rr_ptr=g+1 (wrap at REQ_COUNT), counter=0.
  - Transfer that makes counter==MAX_FRAME_LEN with last=0: forced release. Go to IDLE, pulse frame_abort_o for 1 cycle, abort_count_o+1 saturating at 255, rr_ptr=g+1. Remaining bytes of that requester are arbitrated as a new frame.
  - Last on the MAX_FRAME_LEN-th byte is a normal end, not an abort.
- busy_o=1 in PASS/HDR. grant_o is registered and changes only on state transitions.
- Simultaneous valid from all requesters after reset: order is 0,1,2,3,0...
- A single repeated requester is granted back-to-back, with the 1-cycle IDLE bubble between frames.
- A new request arriving while another frame is in progress waits; it does not preempt.
- Reset mid-frame: the frame is dropped immediately with no abort pulse or count.

Optional Feature:
- Macro UART_TX_ARB_HEADER_EN.
- Defined:
  - After grant, state HDR presents tx_data_o = {4'hA, g[3:0]} with tx_valid_o=1 and all req_ready_o=0, held until tx_ready_i.
  - Then go to PASS.
  - Header bytes are not counted toward MAX_FRAME_LEN.
- Undefined: HDR state absent; IDLE goes directly to PASS; no header byte is emitted.

Test Plan:
- Single frame: requester 2 sends 0x11,0x22,0x33(last), tx_ready_i=1 -> tx sees 0x11,0x22,0x33 in order. grant_o=4'b0100 for 3 cycles, then 0. busy_o drops after the last byte.
- Contention: all 4 valid with 2-byte frames after reset -> frames emitted in requester order 0,1,2,3. No interleaving; exactly one idle bubble between frames.
- Backpressure: tx_ready_i toggles 1/0 per cycle mid-frame -> each byte held stable while ready=0, no byte duplicated or lost. req_ready_o mirrors tx_ready_i only for the owner.
- Overlong frame: MAX_FRAME_LEN=4, requester 1 sends 6 bytes with last only on byte 6. Expected:
  - frame_abort_o pulses once after byte 4, abort_count_o=1.
  - Bytes 5-6 are re-granted as a new frame, since no other requester is pending.
- Abort saturation and reset: force 256 aborts -> abort_count_o holds 255. Assert arst_i mid-frame -> all outputs 0 immediately, next grant starts from requester 0.
- With UART_TX_ARB_HEADER_EN: requester 3 sends 0x5A(last) -> tx sees 0xA3 then 0x5A.
